param_dt_seq_counter: RTL and testbench
=======================================

// Module: param_dt_seq_counter
// PURPOSE
//  Parametrised modulo-N up/down sequence counter whose state register is built
//  from per-bit D or T flip-flops, chosen at elaboration time.
//  Exposes next-state (D) and toggle (T) excitation vectors and a binary/Gray
//  output code, so state-table exercises can be checked against the live design.
//  Generalises fixed 3-bit excitation-logic circuits to any width and modulus.
//  Adds load, direction, Gray coding and a wrap flag.
// PARAMETERS
//  WIDTH    3  state width in bits (>=2)
//  MODULUS  8  sequence length; legal 2..2**WIDTH; state runs 0..MODULUS-1
//  FF_TYPE  0  storage element: 0 = D flip-flops, 1 = T flip-flops
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  en         in   1      count enable
//  up         in   1      1 = count up, 0 = count down (sampled only when en=1)
//  load       in   1      synchronous load, priority over en
//  load_val   in   WIDTH  value to load
//  gray_mode  in   1      1 = code output is Gray, 0 = binary
//  q          out  WIDTH  current state (registered)
//  code       out  WIDTH  q, or q^(q>>1) when gray_mode=1 (combinational from q)
//  d_exc      out  WIDTH  next state = D excitation (combinational)
//  t_exc      out  WIDTH  q ^ d_exc = T excitation (combinational)
//  wrap       out  1      registered 1-cycle pulse after a wrap transition
// BEHAVIOUR
//  - Reset: asserting reset forces q=0 and wrap=0 immediately, with no clock edge.
//    Deassertion is honoured at the next edge. Reset mid-count discards the state.
//  - Next state (d_exc), evaluated in priority order:
//    1. load=1: load_val if load_val<MODULUS, else MODULUS-1 (saturate).
//    2. en=1, up=1: q==MODULUS-1 ? 0 : q+1.
//    3. en=1, up=0: q==0 ? MODULUS-1 : q-1.
//    4. otherwise: q (hold).
//  - Arithmetic is WIDTH bits wide and never exceeds MODULUS-1.
//    With MODULUS=2**WIDTH this reduces to natural wrap-around.
//  - Storage:
//    FF_TYPE=0: q <= d_exc.
//    FF_TYPE=1: each bit is a T-FF, q[i] <= q[i] ^ t_exc[i].
//    Both types produce identical q sequences for identical stimulus.
//  - t_exc is all zeros whenever the counter holds.
//  - wrap: set to 1 at the edge where load=0, en=1 and the step is
//    (up, q==MODULUS-1) or (down, q==0); cleared at every other edge.
//    load=1 together with en=1 means the load wins and wrap=0.
//  - Latency: q changes 1 cycle after a qualifying edge. code, d_exc and t_exc
//    follow q and the inputs combinationally. wrap lags the wrapping edge by 0
//    cycles (it is registered on that same edge).
//  - gray_mode only affects code. It never alters q or the sequence, and may
//    toggle at any cycle.
//  - No handshake: en and load are sampled every rising edge.
// TESTING
//  1. WIDTH=3, MODULUS=6, up, en=1 from reset -> q: 0,1,2,3,4,5,0.
//     wrap=1 only in the cycle after 5->0. At q=5: d_exc=000, t_exc=101.
//  2. Down count from q=0 (MODULUS=6) -> q=5, wrap=1. Next edge -> q=4, wrap=0.
//  3. load=1, load_val=7, MODULUS=6 -> q=5 (saturated).
//     load=1, en=1, up=1 at q=5, load_val=2 -> q=2, wrap=0.
//  4. Count to q=4, then assert reset between clock edges -> q=0, wrap=0
//     without an edge. Release -> counting resumes 0,1,...
//  5. gray_mode=1 at q=6 (110) -> code=101. Toggle gray_mode -> code=110, q unchanged.
//  6. FF_TYPE=0 and FF_TYPE=1 instances (WIDTH=4, MODULUS=10) driven in lockstep
//     with 500 random en/up/load cycles -> q, wrap identical every cycle,
//     and t_exc == q ^ d_exc always.

Source files
------------

// File: rtl/param_dt_seq_counter.sv
// param_dt_seq_counter: modulo-N up/down counter stored in D or T flip-flops,
// exposing its D/T excitation vectors, a binary/Gray code output and a wrap pulse.
module param_dt_seq_counter #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8,
    parameter int FF_TYPE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             gray_mode,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] code,
    output logic [WIDTH-1:0] d_exc,
    output logic [WIDTH-1:0] t_exc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        q_d = load ? (load_val > MAX ? MAX : load_val)
            : !en  ? q_q
            : up   ? (q_q == MAX ? '0 : q_q + 1'b1)
            :        (q_q == '0 ? MAX : q_q - 1'b1);
        wrap_d = !load && en && (up ? q_q == MAX : q_q == '0);
    end

    assign d_exc = q_d;
    assign t_exc = q_q ^ q_d;
    assign q     = q_q;
    assign wrap  = wrap_q;
    assign code  = gray_mode ? q_q ^ (q_q >> 1) : q_q;

    generate
        if (FF_TYPE == 0) begin : g_dff
            always_ff @(posedge clk or posedge reset) begin
                if (reset) q_q <= '0;
                else       q_q <= q_d;
            end
        end else begin : g_tff
            // each bit is an independent T flip-flop fed by its toggle excitation
            always_ff @(posedge clk or posedge reset) begin
                if (reset) q_q <= '0;
                else for (int i = 0; i < WIDTH; i++) q_q[i] <= q_q[i] ^ t_exc[i];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wrap_q <= 1'b0;
        else       wrap_q <= wrap_d;
    end
endmodule

// File: tb/tb_param_dt_seq_counter.sv
// tb_param_dt_seq_counter: scoreboard bench for D- and T-flip-flop builds of the
// modulo-N counter at MODULUS=6, 10 and 8.
module tb_param_dt_seq_counter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       en_a = 0, up_a = 0, load_a = 0, gm_a = 0;
    logic [2:0] lv_a = '0;
    logic [2:0] q_a0, q_a1, code_a0, code_a1, d_a0, d_a1, t_a0, t_a1;
    logic       w_a0, w_a1;

    logic       en_b = 0, up_b = 0, load_b = 0, gm_b = 0;
    logic [3:0] lv_b = '0;
    logic [3:0] q_b0, q_b1, code_b0, code_b1, d_b0, d_b1, t_b0, t_b1;
    logic       w_b0, w_b1;

    logic       en_c = 0, up_c = 0, load_c = 0, gm_c = 0;
    logic [2:0] lv_c = '0;
    logic [2:0] q_c, code_c, d_c, t_c;
    logic       w_c;

    param_dt_seq_counter #(.WIDTH(3), .MODULUS(6), .FF_TYPE(0)) dut_a0 (
        .clk(clk), .reset(reset), .en(en_a), .up(up_a), .load(load_a), .load_val(lv_a),
        .gray_mode(gm_a), .q(q_a0), .code(code_a0), .d_exc(d_a0), .t_exc(t_a0), .wrap(w_a0));
    param_dt_seq_counter #(.WIDTH(3), .MODULUS(6), .FF_TYPE(1)) dut_a1 (
        .clk(clk), .reset(reset), .en(en_a), .up(up_a), .load(load_a), .load_val(lv_a),
        .gray_mode(gm_a), .q(q_a1), .code(code_a1), .d_exc(d_a1), .t_exc(t_a1), .wrap(w_a1));
    param_dt_seq_counter #(.WIDTH(4), .MODULUS(10), .FF_TYPE(0)) dut_b0 (
        .clk(clk), .reset(reset), .en(en_b), .up(up_b), .load(load_b), .load_val(lv_b),
        .gray_mode(gm_b), .q(q_b0), .code(code_b0), .d_exc(d_b0), .t_exc(t_b0), .wrap(w_b0));
    param_dt_seq_counter #(.WIDTH(4), .MODULUS(10), .FF_TYPE(1)) dut_b1 (
        .clk(clk), .reset(reset), .en(en_b), .up(up_b), .load(load_b), .load_val(lv_b),
        .gray_mode(gm_b), .q(q_b1), .code(code_b1), .d_exc(d_b1), .t_exc(t_b1), .wrap(w_b1));
    param_dt_seq_counter #(.WIDTH(3), .MODULUS(8), .FF_TYPE(1)) dut_c (
        .clk(clk), .reset(reset), .en(en_c), .up(up_c), .load(load_c), .load_val(lv_c),
        .gray_mode(gm_c), .q(q_c), .code(code_c), .d_exc(d_c), .t_exc(t_c), .wrap(w_c));

    int n_cmp = 0, n_err = 0;
    int sb[$];
    int mq_a = 0, mq_b = 0;

    function automatic int nxt(int q, int m, logic e, logic u, logic l, int lv);
        if (l) return lv > m - 1 ? m - 1 : lv;
        if (!e) return q;
        if (u) return q == m - 1 ? 0 : q + 1;
        return q == 0 ? m - 1 : q - 1;
    endfunction

    function automatic int wr(int q, int m, logic e, logic u, logic l);
        return (!l && e && (u ? q == m - 1 : q == 0)) ? 1 : 0;
    endfunction

    // scoreboard entries pack the expected state and wrap as {q, wrap}
    task automatic drive_a(logic e, logic u, logic l, int lv);
        en_a = e; up_a = u; load_a = l; lv_a = 3'(lv);
        sb.push_back(nxt(mq_a, 6, e, u, l, lv) * 2 + wr(mq_a, 6, e, u, l));
        mq_a = nxt(mq_a, 6, e, u, l, lv);
    endtask

    task automatic drive_b(logic e, logic u, logic l, int lv);
        en_b = e; up_b = u; load_b = l; lv_b = 4'(lv);
        sb.push_back(nxt(mq_b, 10, e, u, l, lv) * 2 + wr(mq_b, 10, e, u, l));
        mq_b = nxt(mq_b, 10, e, u, l, lv);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({q_a0, w_a0, q_a1, w_a1} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_a: got %h expected 00", {q_a0, w_a0, q_a1, w_a1});
        end
        n_cmp++;
        if ({q_b0, w_b0, q_b1, w_b1, q_c, w_c} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_bc: got %h expected 0", {q_b0, w_b0, q_b1, w_b1, q_c, w_c});
        end
        @(negedge clk);
        reset = 1'b0;
        mq_a = 0; mq_b = 0;
    endtask

    task automatic test_up_wrap;
        for (int i = 0; i < 6; i++) begin
            int p = mq_a;
            drive_a(1, 1, 0, 0);
            if (p == 5) begin
                #1;
                n_cmp++;
                if (d_a0 !== 3'b000 || t_a0 !== 3'b101 || d_a1 !== 3'b000 || t_a1 !== 3'b101) begin
                    n_err++;
                    $display("FAIL exc_at_5: got d=%b/%b t=%b/%b expected d=000 t=101", d_a0, d_a1, t_a0, t_a1);
                end
            end
            tick;
            begin
                int e = sb.pop_front();
                n_cmp++;
                if ({q_a0, w_a0} !== 4'(e) || {q_a1, w_a1} !== 4'(e)) begin
                    n_err++;
                    $display("FAIL up_step%0d: got %h/%h expected %h", i, {q_a0, w_a0}, {q_a1, w_a1}, 4'(e));
                end
            end
        end
    endtask

    task automatic test_down_wrap;
        for (int i = 0; i < 2; i++) begin
            drive_a(1, 0, 0, 0);
            tick;
            begin
                int e = sb.pop_front();
                n_cmp++;
                if ({q_a0, w_a0} !== 4'(e) || {q_a1, w_a1} !== 4'(e)) begin
                    n_err++;
                    $display("FAIL down_step%0d: got %h/%h expected %h", i, {q_a0, w_a0}, {q_a1, w_a1}, 4'(e));
                end
            end
        end
    endtask

    task automatic test_load;
        drive_a(0, 0, 1, 7);
        tick;
        begin
            int e = sb.pop_front();
            n_cmp++;
            if ({q_a0, w_a0} !== 4'(e) || {q_a1, w_a1} !== 4'(e)) begin
                n_err++;
                $display("FAIL load_sat: got %h/%h expected %h", {q_a0, w_a0}, {q_a1, w_a1}, 4'(e));
            end
        end
        drive_a(1, 1, 1, 2);
        tick;
        begin
            int e = sb.pop_front();
            n_cmp++;
            if ({q_a0, w_a0} !== 4'(e) || {q_a1, w_a1} !== 4'(e)) begin
                n_err++;
                $display("FAIL load_over_en: got %h/%h expected %h", {q_a0, w_a0}, {q_a1, w_a1}, 4'(e));
            end
        end
        drive_a(0, 1, 0, 5);
        #1;
        n_cmp++;
        if (t_a0 !== 3'b000 || t_a1 !== 3'b000 || d_a0 !== 3'(mq_a)) begin
            n_err++;
            $display("FAIL hold_exc: got t=%b/%b d=%b expected t=000 d=%b", t_a0, t_a1, d_a0, 3'(mq_a));
        end
        tick;
        begin
            int e = sb.pop_front();
            n_cmp++;
            if ({q_a0, w_a0} !== 4'(e) || {q_a1, w_a1} !== 4'(e)) begin
                n_err++;
                $display("FAIL hold: got %h/%h expected %h", {q_a0, w_a0}, {q_a1, w_a1}, 4'(e));
            end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 8 && mq_a != 4; i++) begin
            drive_a(1, 1, 0, 0);
            tick;
            void'(sb.pop_front());
        end
        n_cmp++;
        if (q_a0 !== 3'd4 || q_a1 !== 3'd4) begin
            n_err++;
            $display("FAIL pre_reset: got %0d/%0d expected 4", q_a0, q_a1);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if ({q_a0, w_a0, q_a1, w_a1} !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: got %h expected 00", {q_a0, w_a0, q_a1, w_a1});
        end
        #1 reset = 1'b0;
        mq_a = 0; mq_b = 0;
        for (int i = 0; i < 2; i++) begin
            drive_a(1, 1, 0, 0);
            tick;
            begin
                int e = sb.pop_front();
                n_cmp++;
                if ({q_a0, w_a0} !== 4'(e) || {q_a1, w_a1} !== 4'(e)) begin
                    n_err++;
                    $display("FAIL resume%0d: got %h/%h expected %h", i, {q_a0, w_a0}, {q_a1, w_a1}, 4'(e));
                end
            end
        end
    endtask

    task automatic test_gray;
        for (int v = 0; v < 8; v++) begin
            load_c = 1; lv_c = 3'(v); gm_c = 1;
            sb.push_back(v);
            tick;
            load_c = 0;
            begin
                int e = sb.pop_front();
                n_cmp++;
                if (q_c !== 3'(e) || code_c !== 3'(e ^ (e >> 1))) begin
                    n_err++;
                    $display("FAIL gray%0d: got q=%b code=%b expected q=%b code=%b", v, q_c, code_c, 3'(e), 3'(e ^ (e >> 1)));
                end
            end
            gm_c = 0;
            #1;
            n_cmp++;
            if (q_c !== 3'(v) || code_c !== 3'(v)) begin
                n_err++;
                $display("FAIL bin%0d: got q=%b code=%b expected %b", v, q_c, code_c, 3'(v));
            end
        end
    endtask

    task automatic test_lockstep;
        for (int i = 0; i < 500; i++) begin
            gm_b = 1'($urandom_range(0, 1));
            drive_b($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 15)));
            #1;
            n_cmp++;
            if (t_b0 !== (q_b0 ^ d_b0) || t_b1 !== (q_b1 ^ d_b1) || d_b0 !== d_b1 ||
                d_b0 !== 4'(nxt(int'(q_b0), 10, en_b, up_b, load_b, int'(lv_b)))) begin
                n_err++;
                $display("FAIL exc_cyc%0d: got d=%h/%h t=%h/%h q=%h", i, d_b0, d_b1, t_b0, t_b1, q_b0);
            end
            n_cmp++;
            if (code_b0 !== (gm_b ? q_b0 ^ (q_b0 >> 1) : q_b0) || code_b1 !== code_b0) begin
                n_err++;
                $display("FAIL code_cyc%0d: got %h/%h q=%h gray=%b", i, code_b0, code_b1, q_b0, gm_b);
            end
            tick;
            begin
                int e = sb.pop_front();
                n_cmp++;
                if ({q_b0, w_b0} !== 5'(e) || {q_b1, w_b1} !== 5'(e)) begin
                    n_err++;
                    $display("FAIL lock_cyc%0d: got %h/%h expected %h", i, {q_b0, w_b0}, {q_b1, w_b1}, 5'(e));
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_up_wrap;
        test_down_wrap;
        test_load;
        test_async_reset;
        test_gray;
        test_lockstep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
